booth_mul_sequencer: RTL and testbench

- Upstream/downstream control stage for multi_booth_8bit.
- Accepts signed 8-bit operand pairs over a valid/ready interface and holds them stable on the multiplier's a/b.
- Issues the multiplier's one-cycle start (its active-high reset input), waits for rdy, then captures p.
- Optionally accumulates the product into a 24-bit signed accumulator and presents each result downstream over valid/ready, with a timeout error path.

---
 rtl/booth_mul_sequencer.sv | 126 ++++++++++++
 tb/tb_booth_mul_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_sequencer.sv
// Control stage around a multi-cycle Booth multiplier: accepts signed operand
// pairs, pulses the multiplier start, waits for rdy (with timeout) and returns
// the product or a running accumulation downstream over valid/ready.
module booth_mul_sequencer #(
  parameter int WIDTH   = 8,
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_acc,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_start,
  input  logic [2*WIDTH-1:0]   mul_p,
  input  logic                 mul_rdy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               acc_flag_r;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   ext_p_s;
  logic [ACC_W-1:0]   acc_next_s;

  // Sign-extend the product and form the next accumulator value (wraps mod 2^ACC_W)
  always_comb begin
    ext_p_s = {{(ACC_W - 2*WIDTH){mul_p[2*WIDTH-1]}}, mul_p};
    if (acc_flag_r) begin
      acc_next_s = acc_r + ext_p_s;
    end else begin
      acc_next_s = ext_p_s;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      in_ready   <= 1'b1;
      mul_start  <= 1'b0;
      mul_a      <= {WIDTH{1'b0}};
      mul_b      <= {WIDTH{1'b0}};
      out_valid  <= 1'b0;
      out_data   <= {ACC_W{1'b0}};
      out_err    <= 1'b0;
      acc_r      <= {ACC_W{1'b0}};
      acc_flag_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            mul_a      <= in_a;
            mul_b      <= in_b;
            acc_flag_r <= in_acc;
            in_ready   <= 1'b0;
            mul_start  <= 1'b1;
            state_r    <= START;
          end else begin
            in_ready   <= 1'b1;
          end
        end
        START: begin
          // rdy is deliberately not looked at here: it may still be the previous op's
          mul_start <= 1'b0;
          cnt_r     <= {CNT_W{1'b0}};
          state_r   <= WAIT;
        end
        WAIT: begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (mul_rdy) begin
            acc_r     <= acc_next_s;
            out_data  <= acc_next_s;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state_r   <= OUT;
          end else if (cnt_r == CNT_LAST) begin
            out_data  <= {ACC_W{1'b0}};
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state_r   <= OUT;
          end else begin
            state_r   <= WAIT;
          end
        end
        OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= OUT;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          mul_start <= 1'b0;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Self-checking bench: the bench plays the multiplier and keeps its own
// accumulator model computed with plain signed arithmetic.
module tb_booth_mul_sequencer;

  localparam int TMO = 32;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_acc;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_start;
  logic [15:0] mul_p;
  logic        mul_rdy;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_err;

  int          total;
  int          bad;
  logic [23:0] acc_m;

  booth_mul_sequencer #(.WIDTH(8), .ACC_W(24), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_p(mul_p), .mul_rdy(mul_rdy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full operation; lat = WAIT cycles with rdy low before rdy (>= TMO means never)
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic accf,
                        input int lat, input logic [15:0] p, input int stall, input bit stale);
    bit tmo;
    int n;
    int pv;
    int exp_n;
    logic [23:0] exp_d;
    logic exp_e;
    tmo = (lat >= TMO);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    in_valid = 1'b1; in_a = a; in_b = b; in_acc = accf;
    if (stale) begin mul_rdy = 1'b1; mul_p = ~p; end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    total++;
    if (in_ready !== 1'b0 || mul_start !== 1'b1) begin
      bad++; $display("FAIL start_pulse in_ready=%b mul_start=%b exp 0/1", in_ready, mul_start);
    end
    total++;
    if (mul_a !== a || mul_b !== b) begin
      bad++; $display("FAIL latch_ab got=%h/%h exp=%h/%h", mul_a, mul_b, a, b);
    end
    n = 0;
    while (n < 60) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (out_valid === 1'b1) break;
      total++;
      if (mul_start !== 1'b0 || mul_a !== a || mul_b !== b || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL wait_hold n=%0d start=%b a=%h b=%h rdy_in=%b exp 0/%h/%h/0",
                 n, mul_start, mul_a, mul_b, in_ready, a, b);
      end
      if (!tmo && n == lat + 1) begin
        mul_rdy = 1'b1; mul_p = p;
      end else begin
        mul_rdy = 1'b0;
      end
    end
    mul_rdy = 1'b0;
    if (tmo) begin
      exp_d = 24'h0; exp_e = 1'b1; exp_n = TMO + 1;
    end else begin
      pv = int'($signed(p));
      acc_m = accf ? acc_m + 24'(pv) : 24'(pv);
      exp_d = acc_m; exp_e = 1'b0; exp_n = lat + 2;
    end
    total++;
    if (n !== exp_n || out_valid !== 1'b1) begin
      bad++; $display("FAIL latency got=%0d valid=%b exp=%0d", n, out_valid, exp_n);
    end
    total++;
    if (out_data !== exp_d || out_err !== exp_e) begin
      bad++; $display("FAIL result got=%h err=%b exp=%h err=%b", out_data, out_err, exp_d, exp_e);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_err !== exp_e || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d valid=%b data=%h err=%b in_ready=%b exp 1/%h/%b/0",
                 i, out_valid, out_data, out_err, in_ready, exp_d, exp_e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1 || out_data !== exp_d) begin
      bad++;
      $display("FAIL handshake valid=%b err=%b in_ready=%b data=%h exp 0/0/1/%h",
               out_valid, out_err, in_ready, out_data, exp_d);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if (in_ready !== 1'b1 || mul_start !== 1'b0 || mul_a !== 8'h0 || mul_b !== 8'h0 ||
        out_valid !== 1'b0 || out_data !== 24'h0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL %s got in_ready=%b start=%b a=%h b=%h valid=%b data=%h err=%b exp 1/0/0/0/0/0/0",
               tag, in_ready, mul_start, mul_a, mul_b, out_valid, out_data, out_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_state");
    reset = 1'b1;
    acc_m = 24'h0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_single_load();
    run_op(8'h66, 8'h1E, 1'b0, 8, 16'h0BF4, 0, 1'b0);
  endtask

  task automatic test_signed_accumulate();
    run_op(8'h29, 8'h99, 1'b1, 4, 16'hEF81, 1, 1'b0);
    total++;
    if (out_data !== 24'hFFFB75) begin bad++; $display("FAIL accum_const got=%h exp=fffb75", out_data); end
  endtask

  task automatic test_neg_load();
    run_op(8'hB9, 8'hA1, 1'b0, 3, 16'h1A59, 0, 1'b0);
    run_op(8'h00, 8'hE8, 1'b1, 2, 16'h0000, 0, 1'b0);
    total++;
    if (out_data !== 24'h001A59) begin bad++; $display("FAIL neg_load got=%h exp=001a59", out_data); end
  endtask

  task automatic test_stale_rdy();
    run_op(8'h12, 8'h34, 1'b0, 5, 16'h03A8, 0, 1'b1);
  endtask

  task automatic test_timeout();
    run_op(8'h05, 8'h07, 1'b0, 6, 16'h0023, 0, 1'b0);
    run_op(8'h11, 8'h22, 1'b1, 1000, 16'h0000, 2, 1'b0);
    run_op(8'h03, 8'h04, 1'b1, 1, 16'h000C, 0, 1'b0);
    total++;
    if (out_data !== 24'h00002F) begin bad++; $display("FAIL acc_after_timeout got=%h exp=00002f", out_data); end
    // rdy arriving in the final allowed WAIT cycle wins over the timeout
    run_op(8'h02, 8'h02, 1'b1, TMO - 1, 16'h0004, 0, 1'b0);
  endtask

  task automatic test_backpressure_reset();
    run_op(8'h66, 8'h1E, 1'b0, 2, 16'h0BF4, 10, 1'b0);
    in_valid = 1'b1; in_a = 8'h45; in_b = 8'h67; in_acc = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_reset_vals("reset_mid_wait");
    reset = 1'b1;
    acc_m = 24'h0;
    mul_rdy = 1'b1; mul_p = 16'h1BF3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_start !== 1'b0) begin
        bad++;
        $display("FAIL late_rdy cyc=%0d valid=%b in_ready=%b start=%b exp 0/1/0",
                 i, out_valid, in_ready, mul_start);
      end
    end
    mul_rdy = 1'b0;
    run_op(8'h7F, 8'h7F, 1'b1, 0, 16'h3F01, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    int prod;
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      prod = int'($signed(a)) * int'($signed(b));
      run_op(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), 16'(prod),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      run_op(8'h80, 8'h80, 1'b1, 0, 16'h4000, 0, 1'b0);
    end
  endtask

  initial begin
    total = 0; bad = 0; acc_m = 24'h0;
    reset = 1'b0; in_valid = 1'b0; in_a = 8'h0; in_b = 8'h0; in_acc = 1'b0;
    mul_p = 16'h0; mul_rdy = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_load();
    test_signed_accumulate();
    test_neg_load();
    test_stale_rdy();
    test_timeout();
    test_backpressure_reset();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
